// File: rtl/rename_reg_file_pkg.sv
// Shared constants and types for the rename register file.
`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

package rename_reg_file_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int ROB_IDX_W = `ROB_INDEX_BIT;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/rename_reg_file_read_port.sv
// One operand read port: register mux plus same-cycle commit forwarding.
module rrf_read_port
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int NREG_P      = NREG,
  parameter int ROB_IDX_W_P = ROB_IDX_W,
  parameter int NCMT        = 1
) (
  input  logic [REG_IDX_W-1:0]               rd_id,
  input  logic [NREG_P-1:0][XLEN_P-1:0]      vals,
  input  logic [NREG_P-1:0][ROB_IDX_W_P-1:0] deps,
  input  logic [NREG_P-1:0]                  has_deps,
  input  logic [NCMT-1:0]                    cmt_valid,
  input  logic [NCMT*REG_IDX_W-1:0]          cmt_rd,
  input  logic [NCMT*XLEN_P-1:0]             cmt_val,
  input  logic [NCMT*ROB_IDX_W_P-1:0]        cmt_rob,
  output logic [XLEN_P-1:0]                  val,
  output logic [ROB_IDX_W_P-1:0]             dep,
  output logic                               has_dep
);

  // Select the stored entry, then let a matching commit slot bypass it;
  // later (younger) slots override earlier ones.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    val     = vals[rd_id];
    dep     = deps[rd_id];
    has_dep = has_deps[rd_id];
    if (rd_id == '0) begin
      val     = '0;
      dep     = '0;
      has_dep = 1'b0;
    end else if (has_deps[rd_id]) begin
      for (int c = 0; c < NCMT; c++) begin
        if (cmt_valid[c] &&
            cmt_rd[c*REG_IDX_W +: REG_IDX_W] == rd_id &&
            cmt_rob[c*ROB_IDX_W_P +: ROB_IDX_W_P] == deps[rd_id]) begin
          val     = cmt_val[c*XLEN_P +: XLEN_P];
          dep     = '0;
          has_dep = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tag (ROB index + busy),
// N-wide issue tagging, N-wide commit, and commit-to-read forwarding.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int NREG_P      = NREG,
  parameter int ROB_IDX_W_P = ROB_IDX_W,
  parameter int NRD         = 2,
  parameter int NISS        = 1,
  parameter int NCMT        = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          clear,
  input  logic [NRD*REG_IDX_W-1:0]      rd_id,
  output logic [NRD*XLEN_P-1:0]         rd_val,
  output logic [NRD*ROB_IDX_W_P-1:0]    rd_dep,
  output logic [NRD-1:0]                rd_has_dep,
  input  logic [NISS-1:0]               iss_valid,
  input  logic [NISS*REG_IDX_W-1:0]     iss_rd,
  input  logic [NISS*ROB_IDX_W_P-1:0]   iss_rob,
  input  logic [NCMT-1:0]               cmt_valid,
  input  logic [NCMT*REG_IDX_W-1:0]     cmt_rd,
  input  logic [NCMT*XLEN_P-1:0]        cmt_val,
  input  logic [NCMT*ROB_IDX_W_P-1:0]   cmt_rob
);

  logic [NREG_P-1:0][XLEN_P-1:0]      val_q,     val_d;
  logic [NREG_P-1:0][ROB_IDX_W_P-1:0] dep_q,     dep_d;
  logic [NREG_P-1:0]                  has_dep_q, has_dep_d;

  // Next state: commit values first (older than any flush), then tag
  // release, then issue tagging so issue wins over release on the same reg.
  always_comb begin
    val_d     = val_q;
    dep_d     = dep_q;
    has_dep_d = has_dep_q;

    for (int c = 0; c < NCMT; c++) begin
      if (cmt_valid[c] && cmt_rd[c*REG_IDX_W +: REG_IDX_W] != '0)
        val_d[cmt_rd[c*REG_IDX_W +: REG_IDX_W]] = cmt_val[c*XLEN_P +: XLEN_P];
    end

    if (clear) begin
      dep_d     = '0;
      has_dep_d = '0;
    end else begin
      for (int c = 0; c < NCMT; c++) begin
        if (cmt_valid[c] && cmt_rd[c*REG_IDX_W +: REG_IDX_W] != '0 &&
            has_dep_q[cmt_rd[c*REG_IDX_W +: REG_IDX_W]] &&
            dep_q[cmt_rd[c*REG_IDX_W +: REG_IDX_W]] == cmt_rob[c*ROB_IDX_W_P +: ROB_IDX_W_P]) begin
          has_dep_d[cmt_rd[c*REG_IDX_W +: REG_IDX_W]] = 1'b0;
          dep_d[cmt_rd[c*REG_IDX_W +: REG_IDX_W]]     = '0;
        end
      end
      for (int i = 0; i < NISS; i++) begin
        if (iss_valid[i] && iss_rd[i*REG_IDX_W +: REG_IDX_W] != '0) begin
          has_dep_d[iss_rd[i*REG_IDX_W +: REG_IDX_W]] = 1'b1;
          dep_d[iss_rd[i*REG_IDX_W +: REG_IDX_W]]     = iss_rob[i*ROB_IDX_W_P +: ROB_IDX_W_P];
        end
      end
    end
  end

  // State registers: async clear, update only while the pipeline is ready.
  // NOTE: the storage is flops, not a RAM macro, so resetting every entry is
  // intended; x0 is never written and so stays zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: non-blocking assignments for all sequential state.
      val_q     <= '0;
      dep_q     <= '0;
      has_dep_q <= '0;
    end else if (rdy_in) begin
      val_q     <= val_d;
      dep_q     <= dep_d;
      has_dep_q <= has_dep_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    rrf_read_port #(
      .XLEN_P      (XLEN_P),
      .NREG_P      (NREG_P),
      .ROB_IDX_W_P (ROB_IDX_W_P),
      .NCMT        (NCMT)
    ) u_port (
      .rd_id     (rd_id[p*REG_IDX_W +: REG_IDX_W]),
      .vals      (val_q),
      .deps      (dep_q),
      .has_deps  (has_dep_q),
      .cmt_valid (cmt_valid),
      .cmt_rd    (cmt_rd),
      .cmt_val   (cmt_val),
      .cmt_rob   (cmt_rob),
      .val       (rd_val[p*XLEN_P +: XLEN_P]),
      .dep       (rd_dep[p*ROB_IDX_W_P +: ROB_IDX_W_P]),
      .has_dep   (rd_has_dep[p])
    );
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed self-checking bench for rename_reg_file (NRD=2, NISS=1, NCMT=1).
module tb_rename_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear;
  logic [9:0]  rd_id;
  logic [63:0] rd_val;
  logic [7:0]  rd_dep;
  logic [1:0]  rd_has_dep;
  logic [0:0]  iss_valid;
  logic [4:0]  iss_rd;
  logic [3:0]  iss_rob;
  logic [0:0]  cmt_valid;
  logic [4:0]  cmt_rd;
  logic [31:0] cmt_val;
  logic [3:0]  cmt_rob;

  int checks = 0;
  int errors = 0;

  rename_reg_file dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .rd_id      (rd_id),
    .rd_val     (rd_val),
    .rd_dep     (rd_dep),
    .rd_has_dep (rd_has_dep),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_rob    (iss_rob),
    .cmt_valid  (cmt_valid),
    .cmt_rd     (cmt_rd),
    .cmt_val    (cmt_val),
    .cmt_rob    (cmt_rob)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic clr,
                       input logic iv, input logic [4:0] ird, input logic [3:0] irob,
                       input logic cv, input logic [4:0] crd, input logic [31:0] cval,
                       input logic [3:0] crob);
    rdy_in    = rdy;
    clear     = clr;
    iss_valid = iv;
    iss_rd    = ird;
    iss_rob   = irob;
    cmt_valid = cv;
    cmt_rd    = crd;
    cmt_val   = cval;
    cmt_rob   = crob;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0);
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    rd_id = {b, a};
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    idle();
    set_rd(5'd5, 5'd0);
    checks++; if (rd_val[31:0] !== 32'd0) begin errors++; $display("FAIL reset_val got %h exp %h", rd_val[31:0], 32'd0); end
    checks++; if (rd_has_dep[0] !== 1'b0) begin errors++; $display("FAIL reset_has_dep got %b exp 0", rd_has_dep[0]); end
    #3 rst_n_in = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd7, 4'd2, 1'b1, 5'd5, 32'h1234, 4'd0);
    tick();
    idle();
    set_rd(5'd5, 5'd7);
    checks++; if (rd_val[31:0] !== 32'h1234) begin errors++; $display("FAIL pre_reset_val got %h exp %h", rd_val[31:0], 32'h1234); end
    checks++; if (rd_has_dep[1] !== 1'b1) begin errors++; $display("FAIL pre_reset_dep got %b exp 1", rd_has_dep[1]); end
    #1 rst_n_in = 1'b0;
    #1;
    checks++; if (rd_val[31:0] !== 32'd0) begin errors++; $display("FAIL async_reset_val got %h exp %h", rd_val[31:0], 32'd0); end
    checks++; if (rd_has_dep[1] !== 1'b0) begin errors++; $display("FAIL async_reset_has_dep got %b exp 0", rd_has_dep[1]); end
    #1 rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_issue_commit_forward();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
    tick();
    idle();
    set_rd(5'd5, 5'd0);
    checks++; if (rd_has_dep[0] !== 1'b1) begin errors++; $display("FAIL issue_has_dep got %b exp 1", rd_has_dep[0]); end
    checks++; if (rd_dep[3:0] !== 4'd3) begin errors++; $display("FAIL issue_dep got %0d exp 3", rd_dep[3:0]); end
    drive(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'hDEAD, 4'd3);
    #1;
    checks++; if (rd_val[31:0] !== 32'hDEAD) begin errors++; $display("FAIL fwd_val got %h exp %h", rd_val[31:0], 32'hDEAD); end
    checks++; if (rd_has_dep[0] !== 1'b0) begin errors++; $display("FAIL fwd_has_dep got %b exp 0", rd_has_dep[0]); end
    checks++; if (rd_dep[3:0] !== 4'd0) begin errors++; $display("FAIL fwd_dep got %0d exp 0", rd_dep[3:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_val[31:0] !== 32'hDEAD) begin errors++; $display("FAIL commit_stored_val got %h exp %h", rd_val[31:0], 32'hDEAD); end
    checks++; if (rd_has_dep[0] !== 1'b0) begin errors++; $display("FAIL commit_release got %b exp 0", rd_has_dep[0]); end
  endtask

  task automatic test_stale_commit();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 4'd7, 1'b0, 5'd0, 32'd0, 4'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'h11, 4'd3);
    set_rd(5'd5, 5'd0);
    checks++; if (rd_val[31:0] !== 32'hDEAD) begin errors++; $display("FAIL stale_no_fwd_val got %h exp %h", rd_val[31:0], 32'hDEAD); end
    checks++; if (rd_dep[3:0] !== 4'd7) begin errors++; $display("FAIL stale_no_fwd_dep got %0d exp 7", rd_dep[3:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_val[31:0] !== 32'h11) begin errors++; $display("FAIL stale_val got %h exp %h", rd_val[31:0], 32'h11); end
    checks++; if (rd_has_dep[0] !== 1'b1) begin errors++; $display("FAIL stale_has_dep got %b exp 1", rd_has_dep[0]); end
    checks++; if (rd_dep[3:0] !== 4'd7) begin errors++; $display("FAIL stale_dep got %0d exp 7", rd_dep[3:0]); end
  endtask

  task automatic test_issue_beats_release();
    drive(1'b1, 1'b0, 1'b1, 5'd6, 4'd2, 1'b0, 5'd0, 32'd0, 4'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd6, 4'd9, 1'b1, 5'd6, 32'h66, 4'd2);
    set_rd(5'd0, 5'd6);
    checks++; if (rd_val[63:32] !== 32'h66) begin errors++; $display("FAIL same_cycle_fwd_val got %h exp %h", rd_val[63:32], 32'h66); end
    checks++; if (rd_has_dep[1] !== 1'b0) begin errors++; $display("FAIL same_cycle_fwd_has_dep got %b exp 0", rd_has_dep[1]); end
    tick();
    idle();
    #1;
    checks++; if (rd_val[63:32] !== 32'h66) begin errors++; $display("FAIL issue_win_val got %h exp %h", rd_val[63:32], 32'h66); end
    checks++; if (rd_has_dep[1] !== 1'b1) begin errors++; $display("FAIL issue_win_has_dep got %b exp 1", rd_has_dep[1]); end
    checks++; if (rd_dep[7:4] !== 4'd9) begin errors++; $display("FAIL issue_win_dep got %0d exp 9", rd_dep[7:4]); end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b1, 1'b1, 5'd4, 4'd5, 1'b1, 5'd4, 32'h55, 4'd0);
    tick();
    idle();
    set_rd(5'd4, 5'd5);
    checks++; if (rd_val[31:0] !== 32'h55) begin errors++; $display("FAIL clear_cmt_val got %h exp %h", rd_val[31:0], 32'h55); end
    checks++; if (rd_has_dep !== 2'b00) begin errors++; $display("FAIL clear_has_dep_45 got %b exp 00", rd_has_dep); end
    set_rd(5'd6, 5'd7);
    checks++; if (rd_has_dep !== 2'b00) begin errors++; $display("FAIL clear_has_dep_67 got %b exp 00", rd_has_dep); end
    checks++; if (rd_dep !== 8'd0) begin errors++; $display("FAIL clear_dep got %h exp 00", rd_dep); end
  endtask

  task automatic test_x0_and_stall();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 4'd1, 1'b1, 5'd0, 32'hFF, 4'd0);
    set_rd(5'd0, 5'd0);
    checks++; if (rd_val[31:0] !== 32'd0) begin errors++; $display("FAIL x0_same_cycle got %h exp 0", rd_val[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_val[31:0] !== 32'd0) begin errors++; $display("FAIL x0_val got %h exp 0", rd_val[31:0]); end
    checks++; if (rd_has_dep[0] !== 1'b0) begin errors++; $display("FAIL x0_has_dep got %b exp 0", rd_has_dep[0]); end
    checks++; if (rd_dep[3:0] !== 4'd0) begin errors++; $display("FAIL x0_dep got %0d exp 0", rd_dep[3:0]); end
    // Seed x1 = 0x77 and tag x3 so the stalled cycles have something to disturb.
    drive(1'b1, 1'b0, 1'b1, 5'd3, 4'd6, 1'b1, 5'd1, 32'h77, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd2, 4'd4, 1'b1, 5'd1, 32'hAB, 4'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0);
    tick();
    idle();
    set_rd(5'd1, 5'd2);
    checks++; if (rd_val[31:0] !== 32'h77) begin errors++; $display("FAIL stall_val got %h exp %h", rd_val[31:0], 32'h77); end
    checks++; if (rd_has_dep[1] !== 1'b0) begin errors++; $display("FAIL stall_issue got %b exp 0", rd_has_dep[1]); end
    set_rd(5'd3, 5'd0);
    checks++; if (rd_has_dep[0] !== 1'b1) begin errors++; $display("FAIL stall_clear_has_dep got %b exp 1", rd_has_dep[0]); end
    checks++; if (rd_dep[3:0] !== 4'd6) begin errors++; $display("FAIL stall_clear_dep got %0d exp 6", rd_dep[3:0]); end
  endtask

  initial begin
    rd_id = '0;
    test_reset();
    test_issue_commit_forward();
    test_stale_commit();
    test_issue_beats_release();
    test_clear();
    test_x0_and_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
